// File: rtl/ac_gain_meter_pkg.sv
// ac_gain_meter_pkg: shared types and width helpers for the AC gain meter.
//   state_t   : measurement FSM states
//   *_DEF     : default parameter values
//   GW, CNT_W : gain width and window-counter width for the defaults
//   gw_of / cnt_w_of : same widths for arbitrary parameter sets
package ac_gain_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned W_DEF        = 12;
  localparam int unsigned FRAC_DEF     = 8;
  localparam int unsigned WIN_LOG2_DEF = 8;

  localparam int unsigned GW    = W_DEF + FRAC_DEF;
  localparam int unsigned CNT_W = WIN_LOG2_DEF + 1;

  function automatic int unsigned gw_of(input int unsigned w, input int unsigned frac);
    return w + frac;
  endfunction

  function automatic int unsigned cnt_w_of(input int unsigned win_log2);
    return win_log2 + 1;
  endfunction

endpackage

// File: rtl/ac_gain_meter_if.sv
// ac_gain_meter_if: sample/result bundle between the capture front end,
// the gain meter and the result register bank.
//   master : drives start, smp_valid, smp_in, smp_out; observes results
//   slave  : the gain meter; observes samples, drives busy/pp/gain/status
import ac_gain_meter_pkg::*;

interface ac_gain_meter_if #(
  parameter int unsigned W    = W_DEF,
  parameter int unsigned FRAC = FRAC_DEF
);
  logic                         start;
  logic                         smp_valid;
  logic signed [W-1:0]          smp_in;
  logic signed [W-1:0]          smp_out;
  logic                         busy;
  logic [W-1:0]                 pp_in;
  logic [W-1:0]                 pp_out;
  logic [gw_of(W, FRAC)-1:0]    gain;
  logic                         gain_valid;
  logic                         div_zero;

  modport master (
    output start, smp_valid, smp_in, smp_out,
    input  busy, pp_in, pp_out, gain, gain_valid, div_zero
  );

  modport slave (
    input  start, smp_valid, smp_in, smp_out,
    output busy, pp_in, pp_out, gain, gain_valid, div_zero
  );
endinterface

// File: rtl/ac_gain_meter_udiv.sv
// seq_udiv: restoring unsigned divider, one quotient bit per cycle, MSB first.
//   clk, rst : clock, synchronous active-high reset
//   go       : load operands (ignored while running)
//   dividend : N-bit dividend
//   divisor  : W-bit divisor (caller guarantees non-zero)
//   quot     : N-bit quotient, valid when done pulses
//   done     : one-cycle pulse after the last of N iterations
// The load edge already performs the first iteration, so N edges
// (load edge included) produce the full quotient.
import ac_gain_meter_pkg::*;

module seq_udiv #(
  parameter int unsigned N = GW,
  parameter int unsigned W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [N-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [N-1:0] quot,
  output logic         done
);
  localparam int unsigned CW = $clog2(N + 1);

  logic [W-1:0]  rem;
  logic [W-1:0]  dvs;
  logic [N-1:0]  q;
  logic [CW-1:0] cnt;
  logic          running;

  logic          load;
  logic [W-1:0]  r_src;
  logic [W-1:0]  d_src;
  logic [N-1:0]  q_src;
  logic [W:0]    trial;
  logic [W-1:0]  diff;
  logic          qbit;
  logic [W-1:0]  rem_nxt;
  logic [N-1:0]  q_nxt;

  assign load = go && !running;

  always_comb begin
    r_src = load ? '0 : rem;
    q_src = load ? dividend : q;
    d_src = load ? divisor : dvs;
    trial = {r_src, q_src[N-1]};
    // When trial >= divisor the true difference is below the divisor,
    // so the low W bits of the subtraction are exact.
    diff  = trial[W-1:0] - d_src;
    qbit  = (trial >= {1'b0, d_src});
    rem_nxt = qbit ? diff : trial[W-1:0];
    q_nxt   = {q_src[N-2:0], qbit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem     <= '0;
      dvs     <= '0;
      q       <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        rem     <= rem_nxt;
        q       <= q_nxt;
        dvs     <= divisor;
        cnt     <= CW'(1);
        running <= (N > 1);
        done    <= (N == 1);
      end else if (running) begin
        rem <= rem_nxt;
        q   <= q_nxt;
        if (cnt == CW'(N - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign quot = q;

endmodule

// File: rtl/ac_gain_meter.sv
// ac_gain_meter: peak-to-peak of stimulus and response over a window of
// 2^WIN_LOG2 valid samples, then gain = floor((pp_out << FRAC) / pp_in).
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of ac_gain_meter_if
//              start/smp_valid/smp_in/smp_out in;
//              busy/pp_in/pp_out/gain/gain_valid/div_zero out
import ac_gain_meter_pkg::*;

module ac_gain_meter #(
  parameter int unsigned W        = W_DEF,
  parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF,
  parameter int unsigned FRAC     = FRAC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  ac_gain_meter_if.slave  bus
);
  localparam int unsigned QW  = gw_of(W, FRAC);
  localparam int unsigned CW  = cnt_w_of(WIN_LOG2);
  localparam int unsigned WIN = 1 << WIN_LOG2;

  state_t state, state_nxt;

  logic [CW-1:0]       cnt;
  logic signed [W-1:0] in_min, in_max, out_min, out_max;
  logic signed [W-1:0] in_min_n, in_max_n, out_min_n, out_max_n;
  logic [W-1:0]        pp_in_n, pp_out_n;
  logic [W-1:0]        pp_in_r, pp_out_r;
  logic [QW-1:0]       gain_r;
  logic                gain_valid_r, div_zero_r;
  logic                take, last;
  logic                div_go, div_done;
  logic [QW-1:0]       quot;

  // Trackers: next min/max including the sample being captured, so the
  // window's final sample is reflected in pp at the ACQ exit edge.
  always_comb begin
    take      = (state == ACQ) && bus.smp_valid;
    last      = take && (cnt == CW'(WIN - 1));
    in_min_n  = in_min;
    in_max_n  = in_max;
    out_min_n = out_min;
    out_max_n = out_max;
    if (take) begin
      if (cnt == '0) begin
        in_min_n  = bus.smp_in;
        in_max_n  = bus.smp_in;
        out_min_n = bus.smp_out;
        out_max_n = bus.smp_out;
      end else begin
        if (bus.smp_in  < in_min)  in_min_n  = bus.smp_in;
        if (bus.smp_in  > in_max)  in_max_n  = bus.smp_in;
        if (bus.smp_out < out_min) out_min_n = bus.smp_out;
        if (bus.smp_out > out_max) out_max_n = bus.smp_out;
      end
    end
    // max - min always fits in W unsigned bits, so modulo-2^W is exact.
    pp_in_n  = $unsigned(in_max_n)  - $unsigned(in_min_n);
    pp_out_n = $unsigned(out_max_n) - $unsigned(out_min_n);
  end

  always_comb begin
    state_nxt = state;
    div_go    = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nxt = ACQ;
      ACQ: begin
        if (last) begin
          if (pp_in_n != '0) begin
            state_nxt = DIV;
            div_go    = 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DIV:     if (div_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      in_min       <= '0;
      in_max       <= '0;
      out_min      <= '0;
      out_max      <= '0;
      pp_in_r      <= '0;
      pp_out_r     <= '0;
      gain_r       <= '0;
      gain_valid_r <= 1'b0;
      div_zero_r   <= 1'b0;
    end else begin
      gain_valid_r <= 1'b0;
      if (take) begin
        in_min  <= in_min_n;
        in_max  <= in_max_n;
        out_min <= out_min_n;
        out_max <= out_max_n;
        cnt     <= last ? '0 : cnt + 1'b1;
      end
      if (last) begin
        pp_in_r  <= pp_in_n;
        pp_out_r <= pp_out_n;
        if (pp_in_n == '0) begin
          gain_r       <= '1;
          div_zero_r   <= 1'b1;
          gain_valid_r <= 1'b1;
        end
      end
      if ((state == DIV) && div_done) begin
        gain_r       <= quot;
        div_zero_r   <= 1'b0;
        gain_valid_r <= 1'b1;
      end
    end
  end

  seq_udiv #(
    .N (QW),
    .W (W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .go       (div_go),
    .dividend ({pp_out_n, {FRAC{1'b0}}}),
    .divisor  (pp_in_n),
    .quot     (quot),
    .done     (div_done)
  );

  assign bus.busy       = (state != IDLE);
  assign bus.pp_in      = pp_in_r;
  assign bus.pp_out     = pp_out_r;
  assign bus.gain       = gain_r;
  assign bus.gain_valid = gain_valid_r;
  assign bus.div_zero   = div_zero_r;

endmodule

// File: tb/tb_ac_gain_meter.sv
// tb_ac_gain_meter: directed vectors with hand-computed results for
// ac_gain_meter at W=12, WIN_LOG2=4, FRAC=8.
module tb_ac_gain_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ac_gain_meter_if #(.W(12), .FRAC(8)) bus ();

  ac_gain_meter #(
    .W        (12),
    .WIN_LOG2 (4),
    .FRAC     (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int lat;
  int seen;

  logic signed [11:0] vin  [16];
  logic signed [11:0] vout [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_alt(input int a_in, input int a_out);
    for (int i = 0; i < 16; i++) begin
      vin[i]  = (i % 2 == 0) ? 12'(a_in)  : 12'(-a_in);
      vout[i] = (i % 2 == 0) ? 12'(a_out) : 12'(-a_out);
    end
  endtask

  // Start a measurement and feed the 16 window samples; returns right
  // after the edge that captures the last sample.
  task automatic acquire(input bit gaps, input bit extra_start);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_acq", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 5)) begin
          bus.smp_valid = 1'b0;
          bus.smp_in    = 12'sd2047;
          bus.smp_out   = -12'sd2048;
          tick();
        end
      end
      bus.smp_valid = 1'b1;
      bus.smp_in    = vin[i];
      bus.smp_out   = vout[i];
      if (extra_start && i == 7) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
    end
    bus.smp_valid = 1'b0;
    bus.smp_in    = 12'sd2047;
    bus.smp_out   = -12'sd2048;
  endtask

  // Counts the cycle of the window-end edge as cycle 1.
  task automatic wait_result(input bit extra_start, output int l);
    l = 1;
    while (!bus.gain_valid && l < 60) begin
      if (extra_start && l == 5) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      l++;
    end
    if (!bus.gain_valid) check("gv_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_res(input string name, input int ppi, input int ppo,
                            input int g, input int dz, input int lat_exp, input int l);
    check({name, "_pp_in"},  32'(bus.pp_in),    32'(ppi));
    check({name, "_pp_out"}, 32'(bus.pp_out),   32'(ppo));
    check({name, "_gain"},   32'(bus.gain),     32'(g));
    check({name, "_dz"},     32'(bus.div_zero), 32'(dz));
    check({name, "_lat"},    32'(l),            32'(lat_exp));
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.smp_valid = 1'b0;
    bus.smp_in    = '0;
    bus.smp_out   = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_gv",   32'(bus.gain_valid), 32'd0);
    check("rst_gain", 32'(bus.gain), 32'd0);
    check("rst_pp",   32'({bus.pp_in, bus.pp_out}), 32'd0);
    check("rst_dz",   32'(bus.div_zero), 32'd0);
    tick();

    // 1: +-100 / +-500
    fill_alt(100, 500);
    acquire(1'b0, 1'b0);
    check("s1_busy_div", 32'(bus.busy), 32'd1);
    wait_result(1'b0, lat);
    expect_res("s1", 200, 1000, 1280, 0, 21, lat);
    tick();
    check("s1_gv_pulse", 32'(bus.gain_valid), 32'd0);
    check("s1_idle",     32'(bus.busy), 32'd0);
    check("s1_held",     32'(bus.gain), 32'd1280);

    // 2: +-150 / +-500, then +-400 / +-100
    fill_alt(150, 500);
    acquire(1'b0, 1'b0);
    wait_result(1'b0, lat);
    expect_res("s2a", 300, 1000, 853, 0, 21, lat);
    tick();
    fill_alt(400, 100);
    acquire(1'b0, 1'b0);
    wait_result(1'b0, lat);
    expect_res("s2b", 800, 200, 64, 0, 21, lat);
    tick();

    // 3: constant stimulus -> divide by zero
    fill_alt(500, 500);
    for (int i = 0; i < 16; i++) vin[i] = 12'sd7;
    acquire(1'b0, 1'b0);
    wait_result(1'b0, lat);
    expect_res("s3", 0, 1000, 20'hFFFFF, 1, 1, lat);
    check("s3_busy_done", 32'(bus.busy), 32'd1);
    tick();
    check("s3_busy_drop", 32'(bus.busy), 32'd0);
    check("s3_gv_pulse",  32'(bus.gain_valid), 32'd0);

    // 4: full-scale sweeps, then zero response
    for (int i = 0; i < 16; i++) begin
      vin[i]  = 12'(-2048 + i * 273);
      vout[i] = 12'(-2048 + i * 273);
    end
    acquire(1'b0, 1'b0);
    wait_result(1'b0, lat);
    expect_res("s4a", 4095, 4095, 256, 0, 21, lat);
    tick();
    fill_alt(1, 0);
    for (int i = 0; i < 16; i++) vout[i] = -12'sd2048;
    acquire(1'b0, 1'b0);
    wait_result(1'b0, lat);
    expect_res("s4b", 2, 0, 0, 0, 21, lat);
    tick();

    // 5: gaps, stray starts in ACQ/DIV/DONE, back-to-back start
    fill_alt(100, 500);
    acquire(1'b1, 1'b1);
    wait_result(1'b1, lat);
    expect_res("s5", 200, 1000, 1280, 0, 21, lat);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("s5_start_in_done", 32'(bus.busy), 32'd0);
    fill_alt(150, 500);
    acquire(1'b0, 1'b0);
    wait_result(1'b0, lat);
    expect_res("s5b2b", 300, 1000, 853, 0, 21, lat);
    tick();

    // 6: reset during DIV
    fill_alt(100, 500);
    acquire(1'b0, 1'b0);
    repeat (5) tick();
    check("s6_in_div", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s6_busy", 32'(bus.busy), 32'd0);
    check("s6_gv",   32'(bus.gain_valid), 32'd0);
    check("s6_gain", 32'(bus.gain), 32'd0);
    check("s6_pp",   32'({bus.pp_in, bus.pp_out}), 32'd0);
    check("s6_dz",   32'(bus.div_zero), 32'd0);
    seen = 0;
    repeat (30) begin
      tick();
      if (bus.gain_valid) seen++;
    end
    check("s6_no_gv", 32'(seen), 32'd0);
    acquire(1'b0, 1'b0);
    wait_result(1'b0, lat);
    expect_res("s6_after", 200, 1000, 1280, 0, 21, lat);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
